// File: rtl/riscv_single_pkg.sv
// Shared encodings for the single-cycle RV32I subset core: opcodes,
// control enums, the decoded-control bundle and immediate extension.
package riscv_single_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_ctrl_e;
   typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;
   typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        alu_src;
      logic        branch;
      logic        jump;
      imm_src_e    imm_src;
      result_src_e result_src;
      alu_ctrl_e   alu_ctrl;
   } ctrl_t;

   // B and J formats already carry a byte offset with bit 0 forced to 0.
   function automatic logic [31:0] ext_imm(input logic [31:7] ins, input imm_src_e src);
      logic [31:0] imm;
      case (src)
         IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_J:   imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/riscv_single_regfile.sv
// 32x32 register file: two combinational read ports, one write port.
// Reads see the pre-edge contents; x0 is never written and stays 0.
module riscv_single_regfile
   import riscv_single_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic        we,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0][31:0] regs;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         regs <= '0;
      else if (we && (wa != 5'd0))
         regs[wa] <= wd;
   end

   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];

endmodule

// File: rtl/riscv_single.sv
// Single-cycle RV32I subset core: combinational decode, ALU and next-PC
// logic around a PC register and the register file.
module riscv_single
   import riscv_single_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] PC,
   input  logic [31:0] Instr,
   output logic        MemWrite,
   output logic [31:0] ALUResult,
   output logic [31:0] WriteData,
   input  logic [31:0] ReadData
);

   ctrl_t       ctrl;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic [31:0] rd1, rd2, imm, src_b, result;
   logic [31:0] pc_plus4, pc_target, pc_next;
   logic        zero, reg_we;

   assign opcode   = Instr[6:0];
   assign funct3   = Instr[14:12];
   assign funct7_5 = Instr[30];

   // Unrecognised opcodes fall through with all enables low, i.e. a NOP.
   always_comb begin
      ctrl            = '0;
      ctrl.imm_src    = IMM_I;
      ctrl.result_src = RES_ALU;
      ctrl.alu_ctrl   = ALU_ADD;
      case (opcode)
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RES_MEM;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.imm_src   = IMM_S;
         end
         OP_RTYPE: begin
            ctrl.reg_write = 1'b1;
            case (funct3)
               F3_ADD:  ctrl.alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
               F3_SLT:  ctrl.alu_ctrl = ALU_SLT;
               F3_OR:   ctrl.alu_ctrl = ALU_OR;
               F3_AND:  ctrl.alu_ctrl = ALU_AND;
               default: ctrl.alu_ctrl = ALU_ADD;
            endcase
         end
         OP_ITYPE: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            case (funct3)
               F3_SLT:  ctrl.alu_ctrl = ALU_SLT;
               F3_OR:   ctrl.alu_ctrl = ALU_OR;
               F3_AND:  ctrl.alu_ctrl = ALU_AND;
               default: ctrl.alu_ctrl = ALU_ADD;
            endcase
         end
         OP_BEQ: begin
            ctrl.branch   = 1'b1;
            ctrl.imm_src  = IMM_B;
            ctrl.alu_ctrl = ALU_SUB;
         end
         OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.imm_src    = IMM_J;
            ctrl.result_src = RES_PC4;
         end
         default: ;
      endcase
   end

   // Side effects are suppressed while reset is held so a stalled store
   // or write-back never leaks out.
   assign reg_we   = ctrl.reg_write & reset;
   assign MemWrite = ctrl.mem_write & reset;

   riscv_single_regfile u_rf (
      .clk   (clk),
      .reset (reset),
      .ra1   (Instr[19:15]),
      .ra2   (Instr[24:20]),
      .wa    (Instr[11:7]),
      .we    (reg_we),
      .wd    (result),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   assign imm       = ext_imm(Instr[31:7], ctrl.imm_src);
   assign src_b     = ctrl.alu_src ? imm : rd2;
   assign WriteData = rd2;

   always_comb begin
      ALUResult = '0;
      case (ctrl.alu_ctrl)
         ALU_ADD: ALUResult = rd1 + src_b;
         ALU_SUB: ALUResult = rd1 - src_b;
         ALU_AND: ALUResult = rd1 & src_b;
         ALU_OR:  ALUResult = rd1 | src_b;
         ALU_SLT: ALUResult = {31'b0, $signed(rd1) < $signed(src_b)};
         default: ALUResult = '0;
      endcase
   end

   assign zero      = (ALUResult == 32'd0);
   assign pc_plus4  = PC + 32'd4;
   assign pc_target = PC + imm;
   assign pc_next   = ((ctrl.branch & zero) | ctrl.jump) ? pc_target : pc_plus4;

   always_comb begin
      result = ALUResult;
      case (ctrl.result_src)
         RES_MEM: result = ReadData;
         RES_PC4: result = pc_plus4;
         default: result = ALUResult;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         PC <= RESET_PC;
      else
         PC <= pc_next;
   end

endmodule

// File: tb/tb_riscv_single.sv
// Directed bench for riscv_single: hand-encoded instructions, expected
// values worked out by hand, register contents observed through the ALU.
module tb_riscv_single;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC, Instr, ALUResult, WriteData, ReadData;
   logic        MemWrite;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   riscv_single dut (
      .clk       (clk),
      .reset     (reset),
      .PC        (PC),
      .Instr     (Instr),
      .MemWrite  (MemWrite),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic exec(input logic [31:0] ins);
      @(negedge clk);
      Instr = ins;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b0;
      Instr    = 32'h0020a023;
      ReadData = 32'h0;
      #2;
      check("rst_pc", PC, 32'h0);
      check("rst_mw", {31'b0, MemWrite}, 32'h0);

      // release while clk is low; first edge executes the instruction at 0
      @(negedge clk);
      reset = 1'b1;
      Instr = 32'h00200093;                   // addi x1,x0,2
      #1;
      check("addi1_alu", ALUResult, 32'd2);
      check("addi1_mw", {31'b0, MemWrite}, 32'h0);
      check("addi1_pc", PC, 32'h0);
      tick;
      check("pc_4", PC, 32'd4);

      exec(32'h00208093);                     // addi x1,x1,2 (old x1=2)
      check("addi2_alu", ALUResult, 32'd4);
      tick;
      check("pc_8", PC, 32'd8);

      exec(32'h00208033);                     // add x0,x1,x2
      check("add_x0_alu", ALUResult, 32'd4);
      check("add_x0_wd", WriteData, 32'd0);
      tick;
      check("pc_12", PC, 32'd12);

      ReadData = 32'hDEADBEEF;
      exec(32'h00008083);                     // lb x1,0(x1) -> word load
      check("lb_alu", ALUResult, 32'd4);
      check("lb_mw", {31'b0, MemWrite}, 32'h0);
      tick;
      check("pc_16", PC, 32'd16);
      ReadData = 32'h0;

      exec(32'hffdff06f);                     // jal x0,-4
      tick;
      check("jal_back_pc", PC, 32'd12);

      exec(32'h00000293);                     // addi x5,x0,0
      check("x0_zero", ALUResult, 32'd0);
      tick;
      exec(32'h00008333);                     // add x6,x1,x0
      check("x1_loaded", ALUResult, 32'hDEADBEEF);
      tick;
      check("pc_20", PC, 32'd20);

      exec(32'h123450B7);                     // lui: unsupported -> NOP
      check("nop_lui_mw", {31'b0, MemWrite}, 32'h0);
      tick;
      check("nop_lui_pc", PC, 32'd24);
      exec(32'h00008333);
      check("nop_no_wb", ALUResult, 32'hDEADBEEF);
      tick;
      exec(32'h00000000);
      check("nop0_mw", {31'b0, MemWrite}, 32'h0);
      tick;
      check("nop0_pc", PC, 32'd32);

      exec(32'h00800093); tick;               // addi x1,x0,8
      exec(32'h00500113);                     // addi x2,x0,5
      check("addi_x2", ALUResult, 32'd5);
      tick;
      exec(32'h0020a023);                     // sw x2,0(x1)
      check("sw_mw", {31'b0, MemWrite}, 32'h1);
      check("sw_alu", ALUResult, 32'd8);
      check("sw_wd", WriteData, 32'd5);
      tick;
      check("pc_44", PC, 32'd44);

      exec(32'h401101B3); check("sub", ALUResult, 32'hFFFFFFFD); tick;
      exec(32'h0011A233); check("slt_neg", ALUResult, 32'd1); tick;
      exec(32'h0020F2B3); check("and", ALUResult, 32'd0); tick;
      exec(32'h0020E2B3); check("or", ALUResult, 32'hD); tick;
      exec(32'h0F01F313); check("andi", ALUResult, 32'hF0); tick;
      exec(32'hFFF06313); check("ori_sext", ALUResult, 32'hFFFFFFFF); tick;
      exec(32'hFFF0A393); check("slti_0", ALUResult, 32'd0); tick;
      exec(32'hFFE1A393); check("slti_1", ALUResult, 32'd1); tick;
      check("pc_76", PC, 32'd76);

      exec(32'h00108463);                     // beq x1,x1,+8
      check("beq_t_alu", ALUResult, 32'd0);
      tick;
      check("beq_taken", PC, 32'd84);
      exec(32'h00208463);                     // beq x1,x2,+8
      tick;
      check("beq_not_taken", PC, 32'd88);
      exec(32'hFE000CE3);                     // beq x0,x0,-8
      tick;
      check("beq_back", PC, 32'd80);
      exec(32'h0080046F);                     // jal x8,+8
      tick;
      check("jal_fwd", PC, 32'd88);
      exec(32'h000404B3);                     // add x9,x8,x0
      check("jal_link", ALUResult, 32'd84);
      tick;

      exec(32'h0000006f);                     // jal x0,0
      for (int i = 0; i < 50; i++) begin
         tick;
         check("jal_self", PC, 32'd92);
      end

      exec(32'h0020a023);                     // sw x2,0(x1)
      check("pre_rst_mw", {31'b0, MemWrite}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check("midrst_pc", PC, 32'h0);
      check("midrst_mw", {31'b0, MemWrite}, 32'h0);
      tick;
      check("midrst_hold", PC, 32'h0);

      @(negedge clk);
      reset = 1'b1;
      Instr = 32'h0020a023;
      #1;
      check("rst_x1_clr", ALUResult, 32'h0);
      check("rst_x2_clr", WriteData, 32'h0);
      check("post_rst_mw", {31'b0, MemWrite}, 32'h1);
      tick;
      check("post_rst_pc", PC, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
